coin_input_conditioner: RTL and testbench

//  Upstream of the vending Moore FSM. Turns raw, asynchronous, bouncy coin-slot sensor

---
 rtl/coin_input_conditioner_pkg.sv | 25 ++
 rtl/coin_input_conditioner_debounce.sv | 79 +++++++
 rtl/coin_input_conditioner.sv | 147 ++++++++++++++
 tb/tb_coin_input_conditioner.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_input_conditioner_pkg.sv
// Shared definitions for the coin path: arbiter state encodings and coin values
// used by the conditioner, the vending FSM and the display logic.
package coin_input_conditioner_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_EMIT    = 2'b01,
    ARB_HOLDOFF = 2'b10
  } arb_state_e;

  localparam int unsigned NICKEL_CENTS  = 5;
  localparam int unsigned DIME_CENTS    = 10;
  localparam int unsigned FIFTEEN_CENTS = 15;

  // Value in cents of a single accepted coin pulse pair (0 when neither is set).
  function automatic int unsigned coin_cents(input logic nickel, input logic dime);
    int unsigned cents;
    cents = 0;
    if (nickel && dime) cents = FIFTEEN_CENTS;
    else if (nickel)    cents = NICKEL_CENTS;
    else if (dime)      cents = DIME_CENTS;
    return cents;
  endfunction

endpackage

// File: rtl/coin_input_conditioner_debounce.sv
// One coin-slot sensor channel: two-flop synchroniser, stability debouncer and
// rising-edge detector. Edges are only reported once the channel has been seen
// low for a full debounce window after reset, so a sensor stuck high across reset
// is not mistaken for a fresh coin.
module coin_input_conditioner_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q, deb_d;
  logic          deb_dly_q, deb_dly_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] arm_cnt_q, arm_cnt_d;
  logic          armed_q, armed_d;

  // Next-state for synchroniser, debounced level and the arming window.
  always_comb begin
    sync1_d   = raw;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    cnt_d     = cnt_q;
    arm_cnt_d = arm_cnt_q;
    armed_d   = armed_q;

    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (!armed_q) begin
      if (sync2_q) begin
        arm_cnt_d = '0;
      end else if (arm_cnt_q == CNT_LAST) begin
        armed_d   = 1'b1;
        arm_cnt_d = '0;
      end else begin
        arm_cnt_d = arm_cnt_q + CW'(1);
      end
    end
  end

  // Channel registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      cnt_q     <= cnt_d;
      arm_cnt_q <= arm_cnt_d;
      armed_q   <= armed_d;
    end
  end

  assign rise = armed_q & deb_q & ~deb_dly_q;

endmodule

// File: rtl/coin_input_conditioner.sv
// Coin input conditioner: turns bouncy asynchronous nickel/dime sensor levels into
// clean, mutually exclusive one-cycle Nickel/Dime pulses for the vending FSM, and
// flags discarded coins (simultaneous, duplicate pending, or acceptance disabled).
module coin_input_conditioner
  import coin_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLDOFF_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       nickel_raw,
  input  logic       dime_raw,
  input  logic       accept_en,
  output logic       Nickel,
  output logic       Dime,
  output logic       coin_reject,
  output logic       busy,
  output logic [1:0] State_out
);

  localparam int unsigned HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

  logic          nickel_rise, dime_rise;
  arb_state_e    state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          nickel_pend_q, nickel_pend_d;
  logic          dime_pend_q, dime_pend_d;
  logic          nickel_q, nickel_d;
  logic          dime_q, dime_d;
  logic          reject_q, reject_d;
  logic          nickel_take, dime_take;
  logic          issue;

  coin_input_conditioner_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_nickel_deb (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (nickel_raw),
    .rise    (nickel_rise)
  );

  coin_input_conditioner_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_dime_deb (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (dime_raw),
    .rise    (dime_rise)
  );

  // Arbiter: issue one pending coin at a time (nickel first), then hold off.
  // The last holdoff cycle arbitrates directly so back-to-back coins come out
  // exactly HOLDOFF_CYCLES+1 cycles apart instead of losing a cycle in IDLE.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    nickel_d    = 1'b0;
    dime_d      = 1'b0;
    nickel_take = 1'b0;
    dime_take   = 1'b0;
    issue       = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        issue = 1'b1;
      end
      ARB_EMIT: begin
        hold_cnt_d = HOLD_LAST;
        state_d    = ARB_HOLDOFF;
      end
      ARB_HOLDOFF: begin
        if (hold_cnt_q == '0) begin
          state_d = ARB_IDLE;
          issue   = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q - HW'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    if (issue) begin
      if (nickel_pend_q) begin
        nickel_d    = 1'b1;
        nickel_take = 1'b1;
        state_d     = ARB_EMIT;
      end else if (dime_pend_q) begin
        dime_d    = 1'b1;
        dime_take = 1'b1;
        state_d   = ARB_EMIT;
      end
    end
  end

  // Capture: latch new coins into their pending slots or reject them.
  always_comb begin
    nickel_pend_d = nickel_pend_q & ~nickel_take;
    dime_pend_d   = dime_pend_q & ~dime_take;
    reject_d      = 1'b0;

    if (nickel_rise && dime_rise) begin
      reject_d = 1'b1;
    end else begin
      if (nickel_rise) begin
        if (!accept_en || nickel_pend_q) reject_d = 1'b1;
        else                             nickel_pend_d = 1'b1;
      end
      if (dime_rise) begin
        if (!accept_en || dime_pend_q) reject_d = 1'b1;
        else                           dime_pend_d = 1'b1;
      end
    end
  end

  // State, pending slots and registered pulse outputs; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ARB_IDLE;
      hold_cnt_q    <= '0;
      nickel_pend_q <= 1'b0;
      dime_pend_q   <= 1'b0;
      nickel_q      <= 1'b0;
      dime_q        <= 1'b0;
      reject_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      nickel_pend_q <= nickel_pend_d;
      dime_pend_q   <= dime_pend_d;
      nickel_q      <= nickel_d;
      dime_q        <= dime_d;
      reject_q      <= reject_d;
    end
  end

  assign Nickel      = nickel_q;
  assign Dime        = dime_q;
  assign coin_reject = reject_q;
  assign busy        = (state_q != ARB_IDLE) | nickel_pend_q | dime_pend_q;
  assign State_out   = state_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Bench for coin_input_conditioner: directed scenarios with fixed expected timing,
// then randomised sensor traffic compared cycle by cycle against a window-based model.
module tb_coin_input_conditioner;

  localparam int D = 4;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       nickel_raw = 1'b0;
  logic       dime_raw = 1'b0;
  logic       accept_en = 1'b1;
  logic       Nickel, Dime, coin_reject, busy;
  logic [1:0] State_out;

  int checks = 0;
  int failures = 0;

  coin_input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .HOLDOFF_CYCLES  (H)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .nickel_raw  (nickel_raw),
    .dime_raw    (dime_raw),
    .accept_en   (accept_en),
    .Nickel      (Nickel),
    .Dime        (Dime),
    .coin_reject (coin_reject),
    .busy        (busy),
    .State_out   (State_out)
  );

  always #5 clk = ~clk;

  // Reference model: a coin level is the synced sensor once the last D synced samples
  // agree; a coin counts if its channel saw D lows since reset; pulses are spaced by
  // an earliest-next-issue time.
  bit         m_raw1[2], m_raw2[2], m_deb[2], m_deb_old[2], m_armed[2];
  int         m_zero_run[2];
  logic [D-1:0] m_win[2];
  bit         m_npend, m_dpend;
  int         m_cyc = 0;
  int         m_next_ok = 0;
  logic       m_nickel = 1'b0, m_dime = 1'b0, m_reject = 1'b0, m_busy = 1'b0;
  logic [1:0] m_state = 2'b00;

  task automatic model_step();
    bit rise[2];
    bit raw_now[2];
    bit en_n, en_d, old_n, old_d, s;
    raw_now[0] = nickel_raw;
    raw_now[1] = dime_raw;
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_raw1[i] = 0; m_raw2[i] = 0; m_deb[i] = 0; m_deb_old[i] = 0;
        m_armed[i] = 0; m_zero_run[i] = 0; m_win[i] = '0;
      end
      m_npend = 0; m_dpend = 0; m_next_ok = 0;
      m_nickel = 0; m_dime = 0; m_reject = 0; m_busy = 0; m_state = 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) rise[i] = m_armed[i] && m_deb[i] && !m_deb_old[i];
      en_n = (m_cyc >= m_next_ok) && m_npend;
      en_d = (m_cyc >= m_next_ok) && !m_npend && m_dpend;
      if (en_n || en_d) begin
        m_state = 2'b01;
        m_next_ok = m_cyc + H + 1;
      end else if (m_cyc < m_next_ok) begin
        m_state = 2'b10;
      end else begin
        m_state = 2'b00;
      end
      old_n = m_npend; old_d = m_dpend;
      if (en_n) m_npend = 0;
      if (en_d) m_dpend = 0;
      m_reject = 0;
      if (rise[0] && rise[1]) m_reject = 1;
      else begin
        if (rise[0]) begin
          if (!accept_en || old_n) m_reject = 1; else m_npend = 1;
        end
        if (rise[1]) begin
          if (!accept_en || old_d) m_reject = 1; else m_dpend = 1;
        end
      end
      m_nickel = en_n;
      m_dime = en_d;
      m_busy = (m_state != 2'b00) || m_npend || m_dpend;
      for (int i = 0; i < 2; i++) begin
        s = m_raw2[i];
        m_deb_old[i] = m_deb[i];
        m_win[i] = {m_win[i][D-2:0], s};
        if (!m_deb[i] && (&m_win[i])) m_deb[i] = 1;
        else if (m_deb[i] && !(|m_win[i])) m_deb[i] = 0;
        m_zero_run[i] = s ? 0 : m_zero_run[i] + 1;
        if (m_zero_run[i] >= D) m_armed[i] = 1;
        m_raw2[i] = m_raw1[i];
        m_raw1[i] = raw_now[i];
      end
    end
    m_cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Drives one scenario from edge 0 and records pulse counts and first edges.
  task automatic run_scenario(input int n, input int nr, input int dr, input bit bounce_d,
                              input int acc_on, output int nc, output int nf, output int dc,
                              output int df, output int rc, output int rf, output int both);
    nc = 0; nf = -1; dc = 0; df = -1; rc = 0; rf = -1; both = 0;
    for (int e = 0; e < n; e++) begin
      nickel_raw = (nr >= 0 && e >= nr);
      dime_raw   = (dr >= 0 && e >= dr) || (bounce_d && e < dr && (e % 2) == 0);
      accept_en  = (e >= acc_on);
      tick();
      if (Nickel === 1'b1) begin nc++; if (nf < 0) nf = e; end
      if (Dime === 1'b1) begin dc++; if (df < 0) df = e; end
      if (coin_reject === 1'b1) begin rc++; if (rf < 0) rf = e; end
      if (Nickel === 1'b1 && Dime === 1'b1) both++;
    end
    nickel_raw = 0; dime_raw = 0; accept_en = 1;
    repeat (D + H + 6) tick();
  endtask

  task automatic test_reset();
    reset_n = 0; nickel_raw = 0; dime_raw = 0; accept_en = 1;
    tick(); tick();
    checks++; if (Nickel !== 1'b0) begin failures++; $display("[TB] FAIL reset_nickel got=%b exp=0", Nickel); end
    checks++; if (Dime !== 1'b0) begin failures++; $display("[TB] FAIL reset_dime got=%b exp=0", Dime); end
    checks++; if (coin_reject !== 1'b0) begin failures++; $display("[TB] FAIL reset_reject got=%b exp=0", coin_reject); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (State_out !== 2'b00) begin failures++; $display("[TB] FAIL reset_state got=%b exp=00", State_out); end
    reset_n = 1;
    repeat (D + 6) tick();
  endtask

  task automatic test_single_nickel();
    int nc, nf, dc, df, rc, rf, both;
    run_scenario(20, 0, -1, 0, 0, nc, nf, dc, df, rc, rf, both);
    checks++; if (nc !== 1) begin failures++; $display("[TB] FAIL single_nickel_count got=%0d exp=1", nc); end
    checks++; if (nf !== D + 3) begin failures++; $display("[TB] FAIL single_nickel_edge got=%0d exp=%0d", nf, D + 3); end
    checks++; if (dc !== 0) begin failures++; $display("[TB] FAIL single_nickel_dime got=%0d exp=0", dc); end
    checks++; if (rc !== 0) begin failures++; $display("[TB] FAIL single_nickel_reject got=%0d exp=0", rc); end
  endtask

  task automatic test_bounce();
    int nc, nf, dc, df, rc, rf, both;
    run_scenario(24, -1, 4, 1, 0, nc, nf, dc, df, rc, rf, both);
    checks++; if (dc !== 1) begin failures++; $display("[TB] FAIL bounce_dime_count got=%0d exp=1", dc); end
    checks++; if (df !== 3 + (4 + D)) begin failures++; $display("[TB] FAIL bounce_dime_edge got=%0d exp=%0d", df, 3 + 4 + D); end
    checks++; if (nc !== 0 || rc !== 0) begin failures++; $display("[TB] FAIL bounce_other got=n%0d/r%0d exp=0/0", nc, rc); end
  endtask

  task automatic test_simultaneous();
    int nc, nf, dc, df, rc, rf, both;
    run_scenario(20, 0, 0, 0, 0, nc, nf, dc, df, rc, rf, both);
    checks++; if (rc !== 1) begin failures++; $display("[TB] FAIL simul_reject_count got=%0d exp=1", rc); end
    checks++; if (rf !== D + 2) begin failures++; $display("[TB] FAIL simul_reject_edge got=%0d exp=%0d", rf, D + 2); end
    checks++; if (nc + dc !== 0) begin failures++; $display("[TB] FAIL simul_pulses got=%0d exp=0", nc + dc); end
  endtask

  task automatic test_back_to_back();
    int nc, nf, dc, df, rc, rf, both;
    run_scenario(24, 0, 1, 0, 0, nc, nf, dc, df, rc, rf, both);
    checks++; if (nf !== D + 3) begin failures++; $display("[TB] FAIL b2b_nickel_edge got=%0d exp=%0d", nf, D + 3); end
    checks++; if (df !== D + 3 + H + 1) begin failures++; $display("[TB] FAIL b2b_dime_edge got=%0d exp=%0d", df, D + 4 + H); end
    checks++; if (nc !== 1 || dc !== 1) begin failures++; $display("[TB] FAIL b2b_counts got=n%0d/d%0d exp=1/1", nc, dc); end
    checks++; if (both !== 0 || rc !== 0) begin failures++; $display("[TB] FAIL b2b_overlap_reject got=%0d/%0d exp=0/0", both, rc); end
  endtask

  task automatic test_accept_disabled();
    int nc, nf, dc, df, rc, rf, both;
    run_scenario(25, 0, -1, 0, 10, nc, nf, dc, df, rc, rf, both);
    checks++; if (rc !== 1) begin failures++; $display("[TB] FAIL accdis_reject_count got=%0d exp=1", rc); end
    checks++; if (rf !== D + 2) begin failures++; $display("[TB] FAIL accdis_reject_edge got=%0d exp=%0d", rf, D + 2); end
    checks++; if (nc !== 0) begin failures++; $display("[TB] FAIL accdis_late_nickel got=%0d exp=0", nc); end
  endtask

  task automatic test_reset_midflight();
    int pulses, rejects;
    nickel_raw = 1; tick();
    dime_raw = 1; tick();
    repeat (7) tick();
    checks++; if (State_out !== 2'b10) begin failures++; $display("[TB] FAIL midrst_pre_state got=%b exp=10", State_out); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL midrst_pre_busy got=%b exp=1", busy); end
    reset_n = 0; tick(); reset_n = 1;
    checks++; if ({Nickel, Dime, coin_reject, busy} !== 4'b0000) begin failures++; $display("[TB] FAIL midrst_outputs got=%b exp=0000", {Nickel, Dime, coin_reject, busy}); end
    checks++; if (State_out !== 2'b00) begin failures++; $display("[TB] FAIL midrst_state got=%b exp=00", State_out); end
    pulses = 0; rejects = 0;
    for (int e = 0; e < 30; e++) begin
      tick();
      if (Nickel === 1'b1 || Dime === 1'b1) pulses++;
      if (coin_reject === 1'b1) rejects++;
    end
    checks++; if (pulses !== 0 || rejects !== 0) begin failures++; $display("[TB] FAIL midrst_after got=p%0d/r%0d exp=0/0", pulses, rejects); end
    nickel_raw = 0; dime_raw = 0;
    repeat (D + H + 6) tick();
  endtask

  task automatic test_random();
    int hold[2];
    bit lvl[2];
    hold[0] = 0; hold[1] = 0; lvl[0] = 0; lvl[1] = 0;
    reset_n = 0; tick(); reset_n = 1;
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (hold[i] == 0) begin
          lvl[i] = 1'($urandom_range(0, 1));
          hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(5, 14));
        end
        hold[i]--;
      end
      nickel_raw = lvl[0];
      dime_raw = lvl[1];
      if ($urandom_range(0, 29) == 0) accept_en = ~accept_en;
      reset_n = ($urandom_range(0, 399) != 0);
      tick();
      checks++; if (Nickel !== m_nickel) begin failures++; $display("[TB] FAIL rand_nickel cyc=%0d got=%b exp=%b", c, Nickel, m_nickel); end
      checks++; if (Dime !== m_dime) begin failures++; $display("[TB] FAIL rand_dime cyc=%0d got=%b exp=%b", c, Dime, m_dime); end
      checks++; if (coin_reject !== m_reject) begin failures++; $display("[TB] FAIL rand_reject cyc=%0d got=%b exp=%b", c, coin_reject, m_reject); end
      checks++; if (busy !== m_busy) begin failures++; $display("[TB] FAIL rand_busy cyc=%0d got=%b exp=%b", c, busy, m_busy); end
      checks++; if (State_out !== m_state) begin failures++; $display("[TB] FAIL rand_state cyc=%0d got=%b exp=%b", c, State_out, m_state); end
      checks++; if ((Nickel & Dime) !== 1'b0) begin failures++; $display("[TB] FAIL rand_exclusive cyc=%0d got=%b exp=0", c, Nickel & Dime); end
    end
    reset_n = 1; accept_en = 1; nickel_raw = 0; dime_raw = 0;
  endtask

  initial begin
    test_reset();
    test_single_nickel();
    test_bounce();
    test_simultaneous();
    test_back_to_back();
    test_accept_disabled();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
